// File: rtl/demux_bit_sequencer.sv
// -----------------------------------------------------------------------------
// demux_bit_sequencer
//
// Upstream driver for a 1:4 demux. Takes single data bits over a valid/ready
// handshake and presents each one on (d, sel) for HOLD_CYCLES cycles, followed
// by GAP_CYCLES cycles of d=0 with sel held. sel only ever changes on the
// accept edge, when d is already 0, so no demux output sees a glitch.
//
// Build option:
//   DEMUX_ADDR_MODE_EN  defined     -> in_addr port exists, the channel is
//                                      taken from in_addr on the accept edge.
//                       not defined -> channels are visited round-robin
//                                      0,1,2,3,0,... by an internal pointer.
//
// All outputs are registered. Reset asserts asynchronously and is expected to
// be released synchronously by the reset tree.
// -----------------------------------------------------------------------------
module demux_bit_sequencer #(
    parameter int HOLD_CYCLES = 4,   // cycles d/sel held per bit, >= 1
    parameter int GAP_CYCLES  = 1,   // idle cycles (d=0) after each bit, >= 0
    parameter int CNT_W       = 8    // width of the hold/gap down-counter
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_data,
`ifdef DEMUX_ADDR_MODE_EN
    input  logic [1:0] in_addr,
`endif
    output logic       in_ready,
    output logic       d,
    output logic [1:0] sel,
    output logic       busy,
    output logic       frame_done
);

    // -------------------------------------------------------------------------
    // Configuration checks (elaboration time)
    // -------------------------------------------------------------------------
    if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
        $error("demux_bit_sequencer: CNT_W=%0d out of range 1..30", CNT_W);
    end

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << CNT_W)) begin : g_bad_hold
        $error("demux_bit_sequencer: HOLD_CYCLES=%0d must be 1..2**CNT_W", HOLD_CYCLES);
    end

    if (GAP_CYCLES < 0 || GAP_CYCLES > (1 << CNT_W)) begin : g_bad_gap
        $error("demux_bit_sequencer: GAP_CYCLES=%0d must be 0..2**CNT_W", GAP_CYCLES);
    end

    // Counter reload values: the counter runs N-1 down to 0, so a phase of N
    // cycles ends on the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       accept_ch;   // channel a newly accepted bit will use

    // in_ready is only ever high in IDLE, so this is the handshake itself.
    logic accept;
    assign accept = (state == ST_IDLE) && in_valid && in_ready;

    // Last cycle of the DRIVE phase: the bit is about to be released.
    logic drive_end;
    assign drive_end = (state == ST_DRIVE) && (cnt == '0);

`ifdef DEMUX_ADDR_MODE_EN
    // Addressed mode: the source names the channel with every bit.
    assign accept_ch = in_addr;
`else
    logic [1:0] rr_ptr;

    assign accept_ch = rr_ptr;

    // Round-robin pointer: advance once per bit as its DRIVE phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (drive_end) begin
            // 2-bit natural wrap gives 3 -> 0.
            rr_ptr <= rr_ptr + 2'd1;
        end
    end
`endif

    // Sequencer FSM: accept a bit, hold it on d/sel, then insert the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            d          <= 1'b0;
            sel        <= 2'b00;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all outputs update together
            // from the pre-edge state; a blocking = would let later lines see
            // half-updated values and break the cycle timing.
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_DRIVE;
                        d        <= in_data;
                        sel      <= accept_ch;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        cnt      <= HOLD_LOAD;
                    end
                end

                ST_DRIVE: begin
                    if (cnt == '0) begin
                        // Bit finished: flag the end of a frame after channel 3.
                        frame_done <= (sel == 2'b11);
                        d          <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state <= ST_GAP;
                            cnt   <= GAP_LOAD;
                        end else begin
                            state    <= ST_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (cnt == '0) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle.
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    d        <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_bit_sequencer
//
// Directed bench for demux_bit_sequencer. Instance A uses HOLD=4, GAP=1;
// instance B uses HOLD=1, GAP=0. With DEMUX_ADDR_MODE_EN defined the bench
// drives in_addr with the same channel order the round-robin mode would use,
// then adds an addressed 3,3,0 sequence.
// -----------------------------------------------------------------------------
module tb_demux_bit_sequencer;

    localparam int A_HOLD = 4;
    localparam int A_GAP  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Instance A
    logic       a_valid = 1'b0;
    logic       a_data  = 1'b0;
`ifdef DEMUX_ADDR_MODE_EN
    logic [1:0] a_addr  = 2'd0;
`endif
    logic       a_ready;
    logic       a_d;
    logic [1:0] a_sel;
    logic       a_busy;
    logic       a_fd;

    // Instance B
    logic       b_valid = 1'b0;
    logic       b_data  = 1'b0;
    logic       b_ready;
    logic       b_d;
    logic [1:0] b_sel;
    logic       b_busy;
    logic       b_fd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_bit_sequencer #(
        .HOLD_CYCLES (A_HOLD),
        .GAP_CYCLES  (A_GAP),
        .CNT_W       (8)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_valid),
        .in_data    (a_data),
`ifdef DEMUX_ADDR_MODE_EN
        .in_addr    (a_addr),
`endif
        .in_ready   (a_ready),
        .d          (a_d),
        .sel        (a_sel),
        .busy       (a_busy),
        .frame_done (a_fd)
    );

    demux_bit_sequencer #(
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (0),
        .CNT_W       (8)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_valid),
        .in_data    (b_data),
`ifdef DEMUX_ADDR_MODE_EN
        .in_addr    (2'd0),
`endif
        .in_ready   (b_ready),
        .d          (b_d),
        .sel        (b_sel),
        .busy       (b_busy),
        .frame_done (b_fd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bit to instance A while it is idle and check every cycle of
    // its 1+HOLD+GAP slot. in_valid stays high throughout (backpressure) and
    // in_data/in_addr are scrambled right after the accept to show they are
    // ignored while busy. Returns in the idle cycle before the next accept.
    task automatic a_bit(input logic b, input logic [1:0] ch);
        check("a_ready_pre", 32'(a_ready), 32'(1'b1));
        a_valid = 1'b1;
        a_data  = b;
`ifdef DEMUX_ADDR_MODE_EN
        a_addr  = ch;
`endif
        step();
        for (int c = 0; c <= A_HOLD + A_GAP; c++) begin
            check("a_d",     32'(a_d),     32'((c < A_HOLD) ? b : 1'b0));
            check("a_sel",   32'(a_sel),   32'(ch));
            check("a_busy",  32'(a_busy),  32'(c < A_HOLD + A_GAP));
            check("a_ready", 32'(a_ready), 32'(c == A_HOLD + A_GAP));
            check("a_fd",    32'(a_fd),    32'((c == A_HOLD) && (ch == 2'd3)));
            if (c == 0) begin
                a_data = ~b;
`ifdef DEMUX_ADDR_MODE_EN
                a_addr = ~ch;
`endif
            end
            if (c < A_HOLD + A_GAP) step();
        end
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_d"},     32'(a_d),     32'(1'b0));
        check({tag, "_sel"},   32'(a_sel),   32'(2'd0));
        check({tag, "_ready"}, 32'(a_ready), 32'(1'b1));
        check({tag, "_busy"},  32'(a_busy),  32'(1'b0));
        check({tag, "_fd"},    32'(a_fd),    32'(1'b0));
    endtask

    initial begin
        // ---- Reset state ---------------------------------------------------
        step();
        step();
        check_a_reset("rst");
        check("rst_b_ready", 32'(b_ready), 32'(1'b1));
        check("rst_b_d",     32'(b_d),     32'(1'b0));
        rst_n = 1'b1;
        step();
        check_a_reset("idle");

        // ---- Bits 1,0,1,1 on ch 0..3, then wrap to ch0 -----------------------
        a_bit(1'b1, 2'd0);
        a_bit(1'b0, 2'd1);
        a_bit(1'b1, 2'd2);
        a_bit(1'b1, 2'd3);
        a_bit(1'b1, 2'd0);
        a_bit(1'b0, 2'd1);

        // ---- Reset in the middle of a ch2 DRIVE --------------------------------
        check("mid_ready_pre", 32'(a_ready), 32'(1'b1));
        a_valid = 1'b1;
        a_data  = 1'b1;
`ifdef DEMUX_ADDR_MODE_EN
        a_addr  = 2'd2;
`endif
        step();
        check("mid_d",    32'(a_d),    32'(1'b1));
        check("mid_sel",  32'(a_sel),  32'(2'd2));
        check("mid_busy", 32'(a_busy), 32'(1'b1));
        step();
        rst_n = 1'b0;
        #1;
        check_a_reset("mid_rst");
        a_valid = 1'b0;
        step();
        check("mid_rst_fd", 32'(a_fd), 32'(1'b0));
        rst_n = 1'b1;
        step();
        check_a_reset("post_rst");
        // Pointer was cleared: the next bit lands on ch0.
        a_bit(1'b1, 2'd0);
        a_valid = 1'b0;

`ifdef DEMUX_ADDR_MODE_EN
        // ---- Addressed channels 3,3,0 ------------------------------------------
        a_bit(1'b1, 2'd3);
        a_bit(1'b0, 2'd3);
        a_bit(1'b1, 2'd0);
        a_valid = 1'b0;
`endif
        step();
        check("a_idle_end", 32'(a_busy), 32'(1'b0));

        // ---- Instance B: HOLD=1, GAP=0, bits 1,1 back-to-back ------------------
        check("b_ready0", 32'(b_ready), 32'(1'b1));
        b_valid = 1'b1;
        b_data  = 1'b1;
        step();
        check("b1_d",     32'(b_d),     32'(1'b1));
        check("b1_sel",   32'(b_sel),   32'(2'd0));
        check("b1_busy",  32'(b_busy),  32'(1'b1));
        check("b1_ready", 32'(b_ready), 32'(1'b0));
        step();
        check("b_gap_d",     32'(b_d),     32'(1'b0));
        check("b_gap_ready", 32'(b_ready), 32'(1'b1));
        check("b_gap_busy",  32'(b_busy),  32'(1'b0));
        check("b_gap_fd",    32'(b_fd),    32'(1'b0));
        step();
        check("b2_d", 32'(b_d), 32'(1'b1));
`ifdef DEMUX_ADDR_MODE_EN
        check("b2_sel", 32'(b_sel), 32'(2'd0));
`else
        check("b2_sel", 32'(b_sel), 32'(2'd1));
`endif
        b_valid = 1'b0;
        step();
        check("b_end_d",     32'(b_d),     32'(1'b0));
        check("b_end_ready", 32'(b_ready), 32'(1'b1));
        step();
        check("b_end_busy", 32'(b_busy), 32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
